reg_file_mp: RTL
================

// Module: reg_file_mp
// PURPOSE
//  Multi-port integer register file for the execution unit. Generalises the 2R/1W file to
//  NUM_RD read ports and NUM_WR write ports with parametrised width and depth.
//  Adds per-port read enables, same-cycle write-to-read bypass and a pending-write scoreboard
//  for issue stalls. Sits between decode/issue (reads, scoreboard set) and writeback (writes).
// PARAMETERS
//  DATA_W    64  register width in bits
//  NUM_REGS  32  number of architectural registers; legal range 2..256
//  NUM_RD     2  read ports
//  NUM_WR     2  write ports
//  ZERO_REG   1  1: register 0 reads as zero, ignores writes, is never pending
//  AW (localparam) = $clog2(NUM_REGS)
// PORTS
//  clk       input   1               clock, all state on posedge
//  rst       input   1               reset, synchronous, active-high
//  ren       input   NUM_RD          per-port read enable
//  raddr     input   NUM_RD*AW       read addresses, port p at [p*AW +: AW]
//  rdata     output  NUM_RD*DATA_W   registered read data, port p at [p*DATA_W +: DATA_W]
//  rd_busy   output  NUM_RD          raddr[p] has a pending write (combinational)
//  we        input   NUM_WR          per-port write enable
//  waddr     input   NUM_WR*AW       write addresses
//  wdata     input   NUM_WR*DATA_W   write data
//  iss_valid input   1               issue of an instruction that will write iss_addr
//  iss_addr  input   AW              destination register of that instruction
//  pending   output  NUM_REGS        scoreboard bitmap, registered
// BEHAVIOUR
//  - Reset: every register, rdata and pending cleared to 0 on the first posedge with rst=1.
//    rst overrides all same-cycle reads, writes and issues.
//  - Read latency 1: at posedge with ren[p]=1, rdata[p] loads the read value; ren[p]=0 holds it.
//  - Read value, in priority order:
//    0 if raddr[p] >= NUM_REGS, or if ZERO_REG=1 and raddr[p]=0;
//    else wdata of the highest-index write port with we=1 and waddr==raddr[p] in the same
//    cycle (bypass);
//    else the stored register.
//  - Write: we[k]=1 updates waddr[k] at posedge. Ignored if waddr>=NUM_REGS, or if
//    ZERO_REG=1 and waddr=0. Several ports on the same address: highest index wins.
//  - Scoreboard, per register r:
//    set when iss_valid && iss_addr==r;
//    cleared when any qualifying write targets r;
//    set and clear in the same cycle: set wins (new producer issued).
//    Register 0 (ZERO_REG=1) and out-of-range addresses are never set.
//  - rd_busy[p] = pending[raddr[p]] from the current registered bitmap. It does not include a
//    same-cycle issue, and it is 0 for the zero register and out-of-range addresses.
//  - All widths unsigned; no X propagation for out-of-range indices.
// STRUCTURE
//  - Package reg_file_pkg: default DATA_W/NUM_REGS constants and function
//    idx_ok(addr, zero_reg), which returns 1 when an address may be written or marked pending.
//  - Sub-module rf_wr_sel: combinational NUM_WR-way priority select. Takes an address and
//    returns hit and the winning wdata. Instantiated once per read port for bypass, and used
//    for storage update.
//  - Storage as reg array [0:NUM_REGS-1]; generate loops over ports.
// TESTING
//  1) rst=1 one cycle after random writes -> all rdata=0, pending=0; reading any reg next
//     gives 0.
//  2) we[0]=1, waddr=5, wdata=64'hA5A5; next cycle ren[0]=1, raddr=5 -> rdata[0]=64'hA5A5
//     one cycle later.
//  3) Same cycle: we[1]=1, waddr=7, wdata=64'h11; ren[1]=1, raddr=7 -> next rdata[1]=64'h11
//     (bypass), reg 7=64'h11.
//  4) we[0], we[1] both to reg 3 with 64'h22 and 64'h33 -> reg 3=64'h33; a bypass read of
//     reg 3 gives 64'h33.
//  5) Write reg 0 with 64'hFF (ZERO_REG=1) -> reads 0; iss_addr=0 -> pending[0] stays 0.
//  6) iss reg 9 -> pending[9]=1 and rd_busy=1 for raddr=9. Writeback reg 9 together with
//     iss reg 9 -> pending[9] stays 1. Writeback alone -> pending[9]=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and address qualification helper for the multi-port register file.
package reg_file_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int NUM_REGS_DEF = 32;

  // True when addr names a real register that may be written or marked pending.
  // Out-of-range addresses and, with zero_reg set, register 0 are excluded.
  function automatic logic idx_ok(input int unsigned addr,
                                  input logic        zero_reg,
                                  input int unsigned num_regs = NUM_REGS_DEF);
    return (addr < num_regs) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/rf_wr_sel.sv
// NUM_WR-way priority select: finds the highest-index write port targeting addr_i.
module rf_wr_sel
  import reg_file_pkg::*;
#(
  parameter int NUM_WR = 2,
  parameter int AW     = 5,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [AW-1:0]            addr_i,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*AW-1:0]     waddr_i,
  input  logic [NUM_WR*DATA_W-1:0] wdata_i,
  output logic                     hit_o,
  output logic [DATA_W-1:0]        data_o
);

  // Scan ports upward so a later (higher-index) match overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we_i[k] && (waddr_i[k*AW +: AW] == addr_i)) begin
        hit_o  = 1'b1;
        data_o = wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with per-port read enables, write-to-read bypass
// and a pending-write scoreboard used by issue to stall on in-flight producers.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD-1:0]        ren_i,
  input  logic [NUM_RD*AW-1:0]     raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*AW-1:0]     waddr_i,
  input  logic [NUM_WR*DATA_W-1:0] wdata_i,
  input  logic                     iss_valid_i,
  input  logic [AW-1:0]            iss_addr_i,
  output logic [NUM_REGS-1:0]      pending_o
);

  localparam logic ZeroRegEn = (ZERO_REG != 0);

  logic [DATA_W-1:0]          regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]        pending_q, pending_d;
  logic [NUM_RD*DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_REGS-1:0]        wrHit;
  logic [NUM_REGS-1:0]        wrEn;
  logic [NUM_REGS*DATA_W-1:0] wrData;
  logic [NUM_RD-1:0]          bypHit;
  logic [NUM_RD*DATA_W-1:0]   bypData;

  // One selector per register resolves which write port (if any) updates it.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_wsel
    rf_wr_sel #(
      .NUM_WR (NUM_WR),
      .AW     (AW),
      .DATA_W (DATA_W)
    ) u_wsel (
      .addr_i  (AW'(r)),
      .we_i    (we_i),
      .waddr_i (waddr_i),
      .wdata_i (wdata_i),
      .hit_o   (wrHit[r]),
      .data_o  (wrData[r*DATA_W +: DATA_W])
    );
    assign wrEn[r] = wrHit[r] && idx_ok(r, ZeroRegEn, NUM_REGS);
  end

  // One selector per read port supplies same-cycle bypass data.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_byp
    rf_wr_sel #(
      .NUM_WR (NUM_WR),
      .AW     (AW),
      .DATA_W (DATA_W)
    ) u_byp (
      .addr_i  (raddr_i[p*AW +: AW]),
      .we_i    (we_i),
      .waddr_i (waddr_i),
      .wdata_i (wdata_i),
      .hit_o   (bypHit[p]),
      .data_o  (bypData[p*DATA_W +: DATA_W])
    );
  end

  // Read value per port (zero, bypass, then storage) and busy flag from the registered scoreboard.
  always_comb begin
    rdata_d   = rdata_q;
    rd_busy_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (idx_ok(32'(raddr_i[p*AW +: AW]), ZeroRegEn, NUM_REGS)) begin
        rd_busy_o[p] = pending_q[raddr_i[p*AW +: AW]];
        if (ren_i[p]) begin
          rdata_d[p*DATA_W +: DATA_W] = bypHit[p] ? bypData[p*DATA_W +: DATA_W]
                                                  : regs_q[raddr_i[p*AW +: AW]];
        end
      end else if (ren_i[p]) begin
        rdata_d[p*DATA_W +: DATA_W] = '0;
      end
    end
  end

  // Writebacks retire producers; a same-cycle issue re-arms the bit since it is a newer producer.
  always_comb begin
    pending_d = pending_q & ~wrEn;
    if (iss_valid_i && idx_ok(32'(iss_addr_i), ZeroRegEn, NUM_REGS)) begin
      pending_d[iss_addr_i] = 1'b1;
    end
  end

  // Register storage update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wrEn[r]) regs_q[r] <= wrData[r*DATA_W +: DATA_W];
      end
    end
  end

  // Registered read data and scoreboard.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q   <= '0;
      pending_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      pending_q <= pending_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign pending_o = pending_q;

endmodule
